spm_sequencer: RTL and testbench
================================

Name: spm_sequencer

Overview:
- Operand sequencer and product collector for the bit-serial signed multiplier array.
- Accepts a parallel operand pair over a valid/ready handshake and drives the array's parallel x bus. Serialises the multiplier LSB-first onto y.
- Captures the array's serial p stream, LSB-first, into a 2*SIZE-bit product and presents it over a valid/ready result handshake.
- Sits between the register/IO front end and the multiplier array; owns the array's clear.

Parameters:
- SIZE, 32, operand width; must match the array's size.
- SIGN_EXT_Y, 1, 1 = fill y with b[SIZE-1] after SIZE bits (signed b); 0 = fill with 0 (unsigned b).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst_n  in  1  reset; synchronous, active-high (asserted = 1).
- in_valid  in  1  operand pair available.
- in_ready  out  1  high only in IDLE.
- a_in  in  SIZE  multiplicand (two's complement), parallel.
- b_in  in  SIZE  multiplier, serialised.
- spm_clr  out  1  array clear, active-high; drives the array's rst_n.
- spm_x  out  SIZE  latched multiplicand to array x.
- spm_y  out  1  serial multiplier bit to array y.
- spm_p  in  1  serial product bit from array p.
- out_valid  out  1  product valid.
- out_ready  in  1  consumer accepts product.
- product  out  2*SIZE  collected product.

Behaviour:
- Reset (rst_n=1 at an edge):
  - state=IDLE; in_ready=1 from the first cycle after reset; out_valid=0; spm_clr=1; spm_y=0; spm_x=0; product=0; counter=0.
  - Reset mid-operation aborts the operation with no output.
- States: IDLE, CLEAR, SHIFT, DRAIN, DONE.
- IDLE:
  - spm_clr=1.
  - in_valid&in_ready at edge: latch a_in->a_reg, b_in->b_sh, counter=0, go CLEAR.
  - Inputs are ignored after acceptance.
- CLEAR (1 cycle):
  - spm_clr=1, so the array's flops clear at the closing edge.
  - Go SHIFT.
- SHIFT (2*SIZE cycles, k = counter = 0..2*SIZE-1):
  - spm_clr=0.
  - spm_y = b_sh[0] combinationally.
  - At each edge, b_sh shifts right with fill = SIGN_EXT_Y ? b_in-latched MSB : 0.
  - Net effect: y = b[k] for k<SIZE, fill bit afterwards.
- Array latency: p during cycle k+1 is product bit k.
- Capture:
  - At the edge closing SHIFT cycles k=1..2*SIZE-1, and at the edge closing DRAIN, do prod <= {spm_p, prod[2*SIZE-1:1]}.
  - That is exactly 2*SIZE captures, and bit 0 ends at product[0].
  - SHIFT cycle 0 does not capture.
- SHIFT->DRAIN when counter==2*SIZE-1.
- DRAIN (1 cycle): spm_y=0, final capture, go DONE.
- DONE:
  - out_valid=1; product stable; spm_clr=0; spm_y=0.
  - Holds until out_ready. At an edge with out_ready=1: out_valid drops, go IDLE.
  - The next in_valid is accepted earliest the following cycle (one-cycle bubble, by design).
- spm_x = a_reg, stable for the whole operation including DONE; 0 only after reset.
- Latency: accept edge -> out_valid high after 2*SIZE+2 cycles (CLEAR 1 + SHIFT 2*SIZE + DRAIN 1).
- Result: product == (a * sext_or_zext(b)) mod 2^(2*SIZE), with a signed.
- Counter width: $clog2(2*SIZE)+1 bits; no wrap within an operation.
- Simultaneous events:
  - in_valid in any non-IDLE state is ignored (in_ready=0).
  - out_ready outside DONE is ignored.
  - rst_n overrides everything.

Decomposition:
- Shared package:
  - state enum (IDLE, CLEAR, SHIFT, DRAIN, DONE).
  - localparam PROD_W = 2*SIZE.
  - counter-width function.
- One natural sub-module: spm_prod_deser, the 2*SIZE-bit right-shift capture register with capture-enable and clear.
- The FSM, counter and b shift register stay in the top.

Test Plan:
- SIZE=8, SIGN_EXT_Y=0, a=0x05, b=0x07, array attached:
  - product=0x0023.
  - out_valid rises exactly 18 cycles after accept.
  - spm_y sequence = 1,1,1,0,0,0,0,0 then 8 zeros.
- SIZE=8, SIGN_EXT_Y=1, a=50 (0x32), b=-50 (0xCE):
  - product=0xF63C.
  - spm_y bits 8..15 all 1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid:
  - product and out_valid stable.
  - in_ready=0 throughout.
  - in_valid pulses ignored.
  - out_ready=1 -> IDLE next cycle.
- Back-to-back: in_valid held high with new a/b; a=-1 (0xFF), b=0x02, SIGN_EXT_Y=1:
  - second accept occurs exactly one cycle after the DONE handshake.
  - products 0x0023 then 0xFFFE.
- Reset mid-SHIFT (k=5): rst_n=1 for one cycle:
  - next cycle out_valid=0, spm_clr=1, in_ready=1.
  - a fresh a=0x03, b=0x04 then yields 0x000C.
- Change a_in/b_in during SHIFT:
  - spm_x unchanged.
  - product reflects the latched values only.

Source files
------------

// File: rtl/spm_sequencer_pkg.sv
// rtl/spm_sequencer_pkg.sv - shared types and sizing helpers for the spm operand sequencer
package spm_sequencer_pkg;

    localparam int DEFAULT_SIZE   = 32;
    localparam int DEFAULT_PROD_W = 2 * DEFAULT_SIZE;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_SHIFT,
        ST_DRAIN,
        ST_DONE
    } state_e;

    // Counter must reach 2*size-1 without wrapping; one spare bit keeps it clear of the edge.
    function automatic int cnt_width(input int size);
        return $clog2(2 * size) + 1;
    endfunction

endpackage

// File: rtl/spm_prod_deser.sv
// rtl/spm_prod_deser.sv - LSB-first serial-to-parallel capture of the array product
module spm_prod_deser
    import spm_sequencer_pkg::*;
#(
    parameter int W = DEFAULT_PROD_W
) (
    input  logic         clk,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         cap_en_i,
    input  logic         bit_i,
    output logic [W-1:0] data_o
);

    logic [W-1:0] data_q;

    // Each capture shifts right and inserts the new bit at the top, so the first bit lands in [0].
    always_ff @(posedge clk) begin
        if (rst_i || clr_i) begin
            data_q <= '0;
        end else if (cap_en_i) begin
            data_q <= {bit_i, data_q[W-1:1]};
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/spm_sequencer.sv
// rtl/spm_sequencer.sv - operand sequencer and product collector for the bit-serial multiplier array
module spm_sequencer
    import spm_sequencer_pkg::*;
#(
    parameter int SIZE       = DEFAULT_SIZE,
    parameter bit SIGN_EXT_Y = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [SIZE-1:0]   a_in,
    input  logic [SIZE-1:0]   b_in,
    output logic              spm_clr,
    output logic [SIZE-1:0]   spm_x,
    output logic              spm_y,
    input  logic              spm_p,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [2*SIZE-1:0] product
);

    localparam int            PW   = 2 * SIZE;
    localparam int            CW   = cnt_width(SIZE);
    localparam logic [CW-1:0] LAST = CW'(PW - 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [SIZE-1:0]   a_q, a_d;
    logic [SIZE-1:0]   b_q, b_d;
    logic              fill;
    logic              cap_en;

    // rst_n is active-high here; it is also the only way spm_x returns to zero.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
        end
    end

    // With sign extension the MSB refills itself, so it keeps the latched b sign for the upper half.
    assign fill = SIGN_EXT_Y ? b_q[SIZE-1] : 1'b0;

    // Next-state, handshake and array-control decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        spm_clr   = 1'b0;
        spm_y     = 1'b0;
        cap_en    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready = 1'b1;
                spm_clr  = 1'b1;
                if (in_valid) begin
                    a_d     = a_in;
                    b_d     = b_in;
                    cnt_d   = '0;
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                spm_clr = 1'b1;
                state_d = ST_SHIFT;
            end
            ST_SHIFT: begin
                spm_y  = b_q[0];
                b_d    = {fill, b_q[SIZE-1:1]};
                // The array output lags y by one cycle, so cycle 0 has nothing to capture yet.
                cap_en = (cnt_q != '0);
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                cap_en  = 1'b1;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign spm_x = a_q;

    spm_prod_deser #(
        .W(PW)
    ) u_deser (
        .clk      (clk),
        .rst_i    (rst_n),
        .clr_i    (state_q == ST_CLEAR),
        .cap_en_i (cap_en),
        .bit_i    (spm_p),
        .data_o   (product)
    );

endmodule

// File: tb/tb_spm_sequencer.sv
// tb/tb_spm_sequencer.sv - self-checking bench for spm_sequencer with behavioural array models
module tb_spm_sequencer;

    localparam int SIZE = 8;
    localparam int PW   = 2 * SIZE;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            in_valid;
    logic            out_ready;
    logic [SIZE-1:0] a_in;
    logic [SIZE-1:0] b_in;

    logic [1:0]      in_ready_w;
    logic [1:0]      out_valid_w;
    logic [1:0]      spm_clr_w;
    logic [1:0]      spm_y_w;
    logic [1:0]      spm_p_w;
    logic [SIZE-1:0] spm_x_w   [2];
    logic [PW-1:0]   product_w [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance 0 treats b as unsigned, instance 1 as signed; both see identical stimulus.
    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic          p_q  = 1'b0;
        logic [PW-1:0] yv   = '0;
        int            acnt = 0;

        spm_sequencer #(
            .SIZE       (SIZE),
            .SIGN_EXT_Y (g == 1)
        ) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready_w[g]),
            .a_in      (a_in),
            .b_in      (b_in),
            .spm_clr   (spm_clr_w[g]),
            .spm_x     (spm_x_w[g]),
            .spm_y     (spm_y_w[g]),
            .spm_p     (spm_p_w[g]),
            .out_valid (out_valid_w[g]),
            .out_ready (out_ready),
            .product   (product_w[g])
        );

        // Array model: after seeing y bits 0..k, bit k of x*y is final and appears on p next cycle.
        always @(posedge clk) begin
            logic [PW-1:0]   yn;
            logic [PW-1:0]   ax;
            logic [2*PW-1:0] pr;
            if (spm_clr_w[g]) begin
                acnt <= 0;
                yv   <= '0;
                p_q  <= 1'b0;
            end else if (acnt < PW) begin
                yn   = yv | (PW'(spm_y_w[g]) << acnt);
                ax   = {{SIZE{spm_x_w[g][SIZE-1]}}, spm_x_w[g]};
                pr   = ax * yn;
                yv   <= yn;
                p_q  <= pr[acnt];
                acnt <= acnt + 1;
            end else begin
                p_q <= 1'b0;
            end
        end
        assign spm_p_w[g] = p_q;
    end

    function automatic logic [PW-1:0] ref_prod(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b, input bit se);
        int ai;
        int bi;
        ai = int'($signed(a));
        bi = se ? int'($signed(b)) : int'(b);
        return PW'(ai * bi);
    endfunction

    function automatic logic [PW-1:0] ref_yvec(input logic [SIZE-1:0] b, input bit se);
        logic [PW-1:0] v;
        for (int k = 0; k < PW; k++) begin
            v[k] = (k < SIZE) ? b[k] : (se ? b[SIZE-1] : 1'b0);
        end
        return v;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expects in_valid high with a/b on the bus and both DUTs in IDLE; runs one full operation.
    task automatic accept_and_run(input logic [SIZE-1:0] a, input logic [SIZE-1:0] b,
                                  input bit keep, input logic [SIZE-1:0] na,
                                  input logic [SIZE-1:0] nb, input int hold);
        int            n;
        int            xbad;
        int            rdybad;
        int            hbad;
        logic [PW-1:0] ys [2];
        logic [PW-1:0] held [2];
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (in_ready_w[i] !== 1'b1) begin
                errors++;
                $display("FAIL accept_ready dut%0d: got %b want 1", i, in_ready_w[i]);
            end
        end
        step();
        if (keep) begin
            a_in = na;
            b_in = nb;
        end else begin
            in_valid = 1'b0;
        end
        n = 0; xbad = 0; rdybad = 0;
        ys[0] = '0; ys[1] = '0;
        while (out_valid_w[0] !== 1'b1 && n < 40) begin
            step();
            n++;
            if (n <= PW) begin
                for (int i = 0; i < 2; i++) ys[i][n-1] = spm_y_w[i];
            end
            for (int i = 0; i < 2; i++) begin
                if (spm_x_w[i] !== a) xbad++;
                if (out_valid_w[i] === 1'b0 && in_ready_w[i] !== 1'b0) rdybad++;
            end
            if (!keep) begin
                a_in     = SIZE'($urandom);
                b_in     = SIZE'($urandom);
                in_valid = 1'($urandom);
            end
        end
        checks++;
        if (n != PW + 2) begin
            errors++;
            $display("FAIL latency: got %0d cycles want %0d", n, PW + 2);
        end
        checks++;
        if (xbad != 0) begin
            errors++;
            $display("FAIL spm_x_stable: %0d bad samples want 0 (a=%h)", xbad, a);
        end
        checks++;
        if (rdybad != 0) begin
            errors++;
            $display("FAIL busy_in_ready: %0d cycles with in_ready high want 0", rdybad);
        end
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid_w[i] !== 1'b1) begin
                errors++;
                $display("FAIL out_valid dut%0d: got %b want 1", i, out_valid_w[i]);
            end
            checks++;
            if (product_w[i] !== ref_prod(a, b, i == 1)) begin
                errors++;
                $display("FAIL product dut%0d a=%h b=%h: got %h want %h", i, a, b, product_w[i], ref_prod(a, b, i == 1));
            end
            checks++;
            if (ys[i] !== ref_yvec(b, i == 1)) begin
                errors++;
                $display("FAIL y_sequence dut%0d b=%h: got %b want %b", i, b, ys[i], ref_yvec(b, i == 1));
            end
            held[i] = product_w[i];
        end
        hbad = 0;
        for (int c = 0; c < hold; c++) begin
            if (!keep) in_valid = 1'($urandom);
            step();
            for (int i = 0; i < 2; i++) begin
                if (product_w[i] !== held[i] || out_valid_w[i] !== 1'b1 || in_ready_w[i] !== 1'b0) hbad++;
            end
        end
        if (hold > 0) begin
            checks++;
            if (hbad != 0) begin
                errors++;
                $display("FAIL backpressure_hold: %0d unstable samples want 0", hbad);
            end
        end
        if (!keep) in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid_w[i] !== 1'b0 || in_ready_w[i] !== 1'b1) begin
                errors++;
                $display("FAIL release dut%0d: out_valid=%b in_ready=%b want 0/1", i, out_valid_w[i], in_ready_w[i]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a_in = '0; b_in = '0;
        step();
        step();
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (in_ready_w[i] !== 1'b1 || out_valid_w[i] !== 1'b0 || spm_clr_w[i] !== 1'b1 ||
                spm_y_w[i] !== 1'b0 || spm_x_w[i] !== '0 || product_w[i] !== '0) begin
                errors++;
                $display("FAIL reset_state dut%0d: rdy=%b ov=%b clr=%b y=%b x=%h p=%h want 1/0/1/0/0/0",
                         i, in_ready_w[i], out_valid_w[i], spm_clr_w[i], spm_y_w[i], spm_x_w[i], product_w[i]);
            end
        end
        rst_n = 1'b0;
        step();
    endtask

    task automatic test_directed();
        in_valid = 1'b1; a_in = 8'h05; b_in = 8'h07;
        accept_and_run(8'h05, 8'h07, 1'b0, '0, '0, 0);
        in_valid = 1'b1; a_in = 8'h32; b_in = 8'hCE;
        accept_and_run(8'h32, 8'hCE, 1'b0, '0, '0, 0);
    endtask

    task automatic test_backpressure();
        in_valid = 1'b1; a_in = 8'hA7; b_in = 8'h9B;
        accept_and_run(8'hA7, 8'h9B, 1'b0, '0, '0, 10);
    endtask

    task automatic test_back_to_back();
        in_valid = 1'b1; a_in = 8'h05; b_in = 8'h07;
        accept_and_run(8'h05, 8'h07, 1'b1, 8'hFF, 8'h02, 0);
        accept_and_run(8'hFF, 8'h02, 1'b0, '0, '0, 0);
    endtask

    task automatic test_reset_mid_shift();
        in_valid = 1'b1; a_in = 8'h5A; b_in = 8'hC3;
        step();
        in_valid = 1'b0;
        repeat (6) step();
        rst_n = 1'b1;
        step();
        rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (out_valid_w[i] !== 1'b0 || spm_clr_w[i] !== 1'b1 || in_ready_w[i] !== 1'b1) begin
                errors++;
                $display("FAIL mid_reset dut%0d: ov=%b clr=%b rdy=%b want 0/1/1",
                         i, out_valid_w[i], spm_clr_w[i], in_ready_w[i]);
            end
        end
        in_valid = 1'b1; a_in = 8'h03; b_in = 8'h04;
        accept_and_run(8'h03, 8'h04, 1'b0, '0, '0, 0);
    endtask

    task automatic test_random();
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
        for (int t = 0; t < 16; t++) begin
            a = SIZE'($urandom);
            b = SIZE'($urandom);
            if (t == 0) begin a = 8'h80; b = 8'h80; end
            if (t == 1) begin a = 8'h7F; b = 8'hFF; end
            in_valid = 1'b1; a_in = a; b_in = b;
            accept_and_run(a, b, 1'b0, '0, '0, $urandom_range(0, 3));
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
